// File: rtl/simple_cpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// simple_cpu_sequencer_if
//   Bundles the sequencer's ROM bus, run control and architectural status
//   outputs so they can be passed as a single port.
//   master : the sequencer (drives rom_addr and the status outputs,
//            receives run and rom_data)
//   slave  : the surrounding system / ROM (drives run and rom_data)
//   Signals
//     run         1 = allow the next fetch, 0 = stall in FETCH
//     rom_addr    ROM address (copy of pc)
//     rom_data    instruction byte returned combinationally by the ROM
//     acc         accumulator
//     pc          program counter
//     carry       carry-out of the last ADD
//     state       00 FETCH, 01 DECODE, 10 EXECUTE
//     instr_done  high during the EXECUTE cycle
// ----------------------------------------------------------------------------
interface simple_cpu_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   logic                  run;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0] rom_data;
   logic [DATA_WIDTH-1:0] acc;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  carry;
   logic [1:0]            state;
   logic                  instr_done;

   modport master (
      input  run,
      input  rom_data,
      output rom_addr,
      output acc,
      output pc,
      output carry,
      output state,
      output instr_done
   );

   modport slave (
      output run,
      output rom_data,
      input  rom_addr,
      input  acc,
      input  pc,
      input  carry,
      input  state,
      input  instr_done
   );
endinterface

// File: rtl/simple_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// simple_cpu_sequencer
//   Fetch/decode/execute controller for the Simple CPU. Addresses the
//   asynchronous instruction ROM with the program counter, captures the
//   returned byte into the instruction register during FETCH, and executes
//   it against the accumulator during EXECUTE. Each instruction takes three
//   cycles (FETCH, DECODE, EXECUTE) while run is held high.
//   Ports
//     clk    single clock, rising edge
//     reset  synchronous, active-high; overrides everything
//     bus    simple_cpu_sequencer_if.master (run, ROM bus, status outputs)
//   Instruction format: opcode = ir[DATA_WIDTH-1 -: 2], operand = low
//   ADDR_WIDTH bits. ADDR_WIDTH must equal DATA_WIDTH-2.
//     00 ADD  {carry,acc} <= acc + operand
//     01 LDI  acc <= operand, carry <= 0
//     10 JMP  pc <= operand
//     11 JZ   pc <= operand when acc == 0
// ----------------------------------------------------------------------------
module simple_cpu_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   simple_cpu_sequencer_if.master   bus
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_DECODE  = 2'b01,
      ST_EXECUTE = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_JMP = 2'b10;
   localparam logic [1:0] OP_JZ  = 2'b11;

   state_t                state_reg;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [DATA_WIDTH-1:0] ir_reg;
   logic [DATA_WIDTH-1:0] acc_reg;
   logic                  carry_reg;

   logic [1:0]            opcode;
   logic [ADDR_WIDTH-1:0] operand;
   logic [DATA_WIDTH-1:0] operand_ext;
   logic [DATA_WIDTH:0]   add_sum;

   assign opcode      = ir_reg[DATA_WIDTH-1 -: 2];
   assign operand     = ir_reg[ADDR_WIDTH-1:0];
   assign operand_ext = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand};
   // One extra bit so the carry-out falls out of the addition directly.
   assign add_sum     = {1'b0, acc_reg} + {1'b0, operand_ext};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_FETCH;
         pc_reg    <= '0;
         ir_reg    <= '0;
         acc_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_FETCH: begin
               // Stalling only happens here, so an instruction that has
               // been fetched always runs to completion.
               if (bus.run) begin
                  ir_reg    <= bus.rom_data;
                  pc_reg    <= pc_reg + 1'b1;
                  state_reg <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state_reg <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               state_reg <= ST_FETCH;
               case (opcode)
                  OP_ADD: begin
                     acc_reg   <= add_sum[DATA_WIDTH-1:0];
                     carry_reg <= add_sum[DATA_WIDTH];
                  end
                  OP_LDI: begin
                     acc_reg   <= operand_ext;
                     carry_reg <= 1'b0;
                  end
                  OP_JMP: begin
                     pc_reg <= operand;
                  end
                  OP_JZ: begin
                     if (acc_reg == '0) begin
                        pc_reg <= operand;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            default: begin
               // Unreachable encoding: recover to FETCH without touching
               // architectural state.
               state_reg <= ST_FETCH;
            end
         endcase
      end
   end

   assign bus.rom_addr   = pc_reg;
   assign bus.pc         = pc_reg;
   assign bus.acc        = acc_reg;
   assign bus.carry      = carry_reg;
   assign bus.state      = state_reg;
   assign bus.instr_done = (state_reg == ST_EXECUTE);

endmodule

// File: tb/tb_simple_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_simple_cpu_sequencer
//   Drives the sequencer from a ROM array held in the bench and compares
//   every cycle against an instruction-level reference model. Directed
//   programs cover the documented scenarios, followed by random programs
//   with random run stalls and occasional resets.
// ----------------------------------------------------------------------------
module tb_simple_cpu_sequencer;

   logic clk;
   logic reset;
   logic [7:0] rom [64];

   simple_cpu_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

   simple_cpu_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.rom_data = rom[bus.rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: architectural state plus which of the three
   // instruction cycles the CPU is in (0 waiting to fetch, 1 decode, 2 execute).
   int m_pc, m_acc, m_carry, m_ir, m_phase;

   task automatic check_eq(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_execute();
      int op, arg, sum;
      op  = m_ir / 64;
      arg = m_ir % 64;
      case (op)
         0: begin
            sum     = m_acc + arg;
            m_acc   = sum % 256;
            m_carry = (sum > 255) ? 1 : 0;
         end
         1: begin
            m_acc   = arg;
            m_carry = 0;
         end
         2: m_pc = arg;
         default: if (m_acc == 0) m_pc = arg;
      endcase
      $display("instr op=%0d arg=%0d -> acc=%0d carry=%0d pc=%0d",
               op, arg, m_acc, m_carry, m_pc);
   endtask

   task automatic model_update(input logic r, input logic rs);
      if (rs) begin
         m_pc = 0; m_acc = 0; m_carry = 0; m_ir = 0; m_phase = 0;
      end else if (m_phase == 0) begin
         if (r) begin
            m_ir    = rom[m_pc];
            m_pc    = (m_pc + 1) % 64;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         model_execute();
         m_phase = 0;
      end
   endtask

   task automatic compare_all();
      check_eq("state",      int'(bus.state),      m_phase);
      check_eq("instr_done", int'(bus.instr_done), (m_phase == 2) ? 1 : 0);
      check_eq("pc",         int'(bus.pc),         m_pc);
      check_eq("rom_addr",   int'(bus.rom_addr),   m_pc);
      check_eq("acc",        int'(bus.acc),        m_acc);
      check_eq("carry",      int'(bus.carry),      m_carry);
   endtask

   // One clock: drive inputs away from the edge, advance model, sample at +1.
   task automatic step(input logic r, input logic rs);
      bus.run = r;
      reset   = rs;
      @(posedge clk);
      model_update(r, rs);
      #1;
      compare_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 8'h00;
   endtask

   initial begin
      bus.run = 1'b0;
      reset   = 1'b1;
      clear_rom();
      m_pc = 0; m_acc = 0; m_carry = 0; m_ir = 0; m_phase = 0;
      #2;

      // Reset state
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check_eq("rst_pc", int'(bus.pc), 0);
      check_eq("rst_state", int'(bus.state), 0);

      // Scenario 1: ADD 3 / JMP 0 loop
      rom[0] = 8'h03; rom[1] = 8'h80;
      step(1'b0, 1'b1);
      steps(3);
      check_eq("t1_acc_first", int'(bus.acc), 3);
      steps(6);
      check_eq("t1_acc_third", int'(bus.acc), 6);
      check_eq("t1_pc_third", int'(bus.pc), 1);

      // Scenario 2: LDI 63 then four ADD 63
      clear_rom();
      rom[0] = 8'h7F;
      for (int i = 1; i < 5; i++) rom[i] = 8'h3F;
      step(1'b0, 1'b1);
      steps(12);
      check_eq("t2_acc4", int'(bus.acc), 252);
      check_eq("t2_carry4", int'(bus.carry), 0);
      steps(3);
      check_eq("t2_acc5", int'(bus.acc), 59);
      check_eq("t2_carry5", int'(bus.carry), 1);

      // Scenario 3: JZ taken, then not taken
      clear_rom();
      rom[0] = 8'h40; rom[1] = 8'hC5; rom[5] = 8'h47;
      step(1'b0, 1'b1);
      steps(6);
      check_eq("t3_jz_taken_pc", int'(bus.pc), 5);
      steps(3);
      check_eq("t3_acc7", int'(bus.acc), 7);
      rom[0] = 8'h41;
      step(1'b0, 1'b1);
      steps(6);
      check_eq("t3_jz_not_taken_pc", int'(bus.pc), 2);

      // Scenario 4: run dropped during DECODE
      clear_rom();
      rom[0] = 8'h03; rom[1] = 8'h80;
      step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      check_eq("t4_execute_state", int'(bus.state), 2);
      step(1'b0, 1'b0);
      check_eq("t4_acc_done", int'(bus.acc), 3);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
      check_eq("t4_frozen_pc", int'(bus.pc), 1);
      step(1'b1, 1'b0);
      check_eq("t4_resume_pc", int'(bus.pc), 2);
      steps(2);

      // Scenario 5: reset during EXECUTE of an ADD
      clear_rom();
      rom[0] = 8'h7F; rom[1] = 8'h3F;
      step(1'b0, 1'b1);
      steps(5);
      check_eq("t5_in_execute", int'(bus.instr_done), 1);
      step(1'b1, 1'b1);
      check_eq("t5_acc", int'(bus.acc), 0);
      check_eq("t5_pc", int'(bus.pc), 0);
      check_eq("t5_state", int'(bus.state), 0);
      check_eq("t5_done", int'(bus.instr_done), 0);

      // Scenario 6: 64 x ADD 0, pc wraps
      clear_rom();
      step(1'b0, 1'b1);
      steps(189);
      check_eq("t6_pc63", int'(bus.pc), 63);
      steps(3);
      check_eq("t6_pc_wrap", int'(bus.pc), 0);
      check_eq("t6_acc", int'(bus.acc), 0);

      // Random programs, random stalls, occasional resets
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
      step(1'b0, 1'b1);
      for (int c = 0; c < 1500; c++) begin
         logic r, rs;
         r  = ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 149) == 0);
         if (rs) begin
            for (int i = 0; i < 64; i++) rom[i] = 8'($urandom_range(0, 255));
         end
         step(r, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
